// File: rtl/ps2_jump_receiver.sv
// PS/2 keyboard receiver with jump-key decode (receive-only; never drives the PS/2 lines).
// Optional build macro PS2_TYPEMATIC_FILTER_EN: suppresses jump pulses for typematic repeat makes.
module ps2_jump_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter logic [7:0]  JUMP_SCANCODE  = 8'h29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       is_break,
  output logic       is_ext,
  output logic       frame_error,
  output logic       jump,
  output logic       jump_held
);

  localparam int unsigned FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  CODE_EXT = 8'hE0;
  localparam logic [7:0]  CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  state_e           state_q, state_d;
  logic             clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic             data_meta_q, data_meta_d, data_sync_q, data_sync_d;
  logic             clk_filt_q, clk_filt_d;
  logic [FCW-1:0]   filt_cnt_q, filt_cnt_d;
  logic             fall_q, fall_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             parity_q, parity_d;
  logic [TCW-1:0]   tmo_q, tmo_d;
  logic             byte_rdy_q, byte_rdy_d;
  logic             ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic [7:0]       scan_code_q, scan_code_d;
  logic             scan_valid_q, scan_valid_d;
  logic             is_break_q, is_break_d, is_ext_q, is_ext_d;
  logic             frame_error_q, frame_error_d;
  logic             jump_q, jump_d, jump_held_q, jump_held_d;
  logic             abort;

  // Line synchronizers and filter reset to the idle-high level so reset never fakes a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      clk_meta_q    <= 1'b1;
      clk_sync_q    <= 1'b1;
      data_meta_q   <= 1'b1;
      data_sync_q   <= 1'b1;
      clk_filt_q    <= 1'b1;
      filt_cnt_q    <= '0;
      fall_q        <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      parity_q      <= 1'b0;
      tmo_q         <= '0;
      byte_rdy_q    <= 1'b0;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      scan_code_q   <= '0;
      scan_valid_q  <= 1'b0;
      is_break_q    <= 1'b0;
      is_ext_q      <= 1'b0;
      frame_error_q <= 1'b0;
      jump_q        <= 1'b0;
      jump_held_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_meta_q    <= clk_meta_d;
      clk_sync_q    <= clk_sync_d;
      data_meta_q   <= data_meta_d;
      data_sync_q   <= data_sync_d;
      clk_filt_q    <= clk_filt_d;
      filt_cnt_q    <= filt_cnt_d;
      fall_q        <= fall_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      parity_q      <= parity_d;
      tmo_q         <= tmo_d;
      byte_rdy_q    <= byte_rdy_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      scan_code_q   <= scan_code_d;
      scan_valid_q  <= scan_valid_d;
      is_break_q    <= is_break_d;
      is_ext_q      <= is_ext_d;
      frame_error_q <= frame_error_d;
      jump_q        <= jump_d;
      jump_held_q   <= jump_held_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    clk_meta_d    = ps2_clk;
    clk_sync_d    = clk_meta_q;
    data_meta_d   = ps2_data;
    data_sync_d   = data_meta_q;
    clk_filt_d    = clk_filt_q;
    filt_cnt_d    = filt_cnt_q;
    fall_d        = 1'b0;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    parity_d      = parity_q;
    tmo_d         = tmo_q;
    byte_rdy_d    = 1'b0;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    scan_code_d   = scan_code_q;
    scan_valid_d  = 1'b0;
    is_break_d    = is_break_q;
    is_ext_d      = is_ext_q;
    frame_error_d = 1'b0;
    jump_d        = 1'b0;
    jump_held_d   = jump_held_q;
    abort         = 1'b0;

    // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples.
    if (clk_sync_q == clk_filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
      clk_filt_d = clk_sync_q;
      filt_cnt_d = '0;
      fall_d     = clk_filt_q;
    end else begin
      filt_cnt_d = filt_cnt_q + FCW'(1);
    end

    if (state_q == S_IDLE || fall_q) tmo_d = '0;
    else                             tmo_d = tmo_q + TCW'(1);

    if (fall_q) begin
      case (state_q)
        S_IDLE: begin
          if (!data_sync_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        S_DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = data_sync_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          if (data_sync_q && (^{shift_q, parity_q})) byte_rdy_d = 1'b1;
          else                                       abort      = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
      abort   = 1'b1;
      state_d = S_IDLE;
    end

    // Byte processing, one cycle after the stop-bit edge; prefixes only arm the pending flags.
    if (byte_rdy_q) begin
      if (shift_q == CODE_EXT) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == CODE_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        scan_code_d  = shift_q;
        is_break_d   = brk_pend_q;
        is_ext_d     = ext_pend_q;
        scan_valid_d = 1'b1;
        ext_pend_d   = 1'b0;
        brk_pend_d   = 1'b0;
        if (shift_q == JUMP_SCANCODE && !ext_pend_q) begin
          if (brk_pend_q) begin
            jump_held_d = 1'b0;
          end else begin
            jump_held_d = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            jump_d      = ~jump_held_q;
`else
            jump_d      = 1'b1;
`endif
          end
        end
      end
    end

    if (abort) begin
      frame_error_d = 1'b1;
      ext_pend_d    = 1'b0;
      brk_pend_d    = 1'b0;
    end
  end

  assign scan_code   = scan_code_q;
  assign scan_valid  = scan_valid_q;
  assign is_break    = is_break_q;
  assign is_ext      = is_ext_q;
  assign frame_error = frame_error_q;
  assign jump        = jump_q;
  assign jump_held   = jump_held_q;

endmodule

// File: tb/tb_ps2_jump_receiver.sv
// Bench for ps2_jump_receiver: directed and random PS/2 frames checked against a scan-code level model.
module tb_ps2_jump_receiver;

  localparam int unsigned FILTER_LEN     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 2000;
  localparam logic [7:0]  JUMP           = 8'h29;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_valid, is_break, is_ext, frame_error, jump, jump_held;

  ps2_jump_receiver #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .JUMP_SCANCODE(JUMP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .scan_code(scan_code),
    .scan_valid(scan_valid),
    .is_break(is_break),
    .is_ext(is_ext),
    .frame_error(frame_error),
    .jump(jump),
    .jump_held(jump_held)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       jmp;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  ev_t mon_e;
  int  obs_ferr = 0, exp_ferr = 0, obs_jump = 0, exp_jump = 0, orphan_jump = 0;
  int  cyc = 0, last_fall_cyc = 0, last_sv_cyc = 0;
  int  checks = 0, errors = 0;
  int  bit_cyc = 800;
  bit  m_ext = 0, m_brk = 0, m_held = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every scan_valid event and counts strobes.
  always @(negedge clk) begin
    if (!reset) begin
      if (scan_valid) begin
        mon_e.code = scan_code;
        mon_e.brk  = is_break;
        mon_e.ext  = is_ext;
        mon_e.jmp  = jump;
        obs_q.push_back(mon_e);
        last_sv_cyc = cyc;
      end else if (jump) begin
        orphan_jump++;
      end
      if (jump) obs_jump++;
      if (frame_error) obs_ferr++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    int h;
    h = bit_cyc / 2;
    ps2_data = b;
    wait_cyc(h / 2);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(h);
    ps2_clk = 1'b1;
    wait_cyc(h - h / 2);
  endtask

  // Frame bit 0 is the start bit; odd parity makes the total count of ones in data+parity odd.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = frame_bits(b, bad_par);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    wait_cyc(100);
  endtask

  // Keyboard-level reference: what the receiver should report for one received byte.
  task automatic model_frame(input logic [7:0] b, input bit good);
    ev_t e;
    if (!good) begin
      m_brk = 0;
      m_ext = 0;
      exp_ferr++;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      e.code = b;
      e.brk  = m_brk;
      e.ext  = m_ext;
      e.jmp  = 1'b0;
      if (b == JUMP && !m_ext) begin
        if (m_brk) begin
          m_held = 0;
        end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
          e.jmp = !m_held;
`else
          e.jmp = 1'b1;
`endif
          m_held = 1;
        end
      end
      if (e.jmp) exp_jump++;
      exp_q.push_back(e);
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic bad_par);
    send_frame(b, bad_par);
    model_frame(b, !bad_par);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, " scan_valid count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, " event {code,brk,ext,jump}"}, 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, " jump pulses"}, 32'(obs_jump), 32'(exp_jump));
    chk({tag, " frame_error strobes"}, 32'(obs_ferr), 32'(exp_ferr));
    chk({tag, " jump_held"}, 32'(jump_held), 32'(m_held));
    chk({tag, " jump without scan_valid"}, 32'(orphan_jump), 32'd0);
    obs_q.delete();
    exp_q.delete();
    obs_ferr = 0; exp_ferr = 0; obs_jump = 0; exp_jump = 0; orphan_jump = 0;
  endtask

  initial begin
    int          d;
    logic [10:0] f;
    logic [7:0]  codes [5];
    logic [7:0]  b;
    logic        bad;

    codes[0] = 8'h29; codes[1] = 8'hF0; codes[2] = 8'hE0; codes[3] = 8'h1C; codes[4] = 8'h00;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    chk("outputs during reset", 32'({scan_code, scan_valid, is_break, is_ext, frame_error, jump, jump_held}), 32'd0);
    reset = 1'b0;
    wait_cyc(20);
    chk("outputs after reset", 32'({scan_code, scan_valid, is_break, is_ext, frame_error, jump, jump_held}), 32'd0);

    // 1: jump make at the nominal bit period
    frame(JUMP, 1'b0);
    d = last_sv_cyc - last_fall_cyc;
    chk("t1 scan_valid latency in window", 32'(d >= 2 && d <= 20), 32'd1);
    compare("t1");
    bit_cyc = 120;

    // 2: break and extended forms of the jump code
    frame(8'hF0, 1'b0);
    frame(JUMP, 1'b0);
    frame(8'hE0, 1'b0);
    frame(JUMP, 1'b0);
    compare("t2");

    // 3: parity error drops the pending break prefix
    frame(8'hF0, 1'b0);
    frame(8'h1C, 1'b1);
    compare("t3 bad parity");
    frame(8'h1C, 1'b0);
    compare("t3 good");

    // 4: partial frame stalls past the timeout, clearing a pending E0
    frame(8'hE0, 1'b0);
    f = frame_bits(JUMP, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(f[i]);
    wait_cyc(2600);
    model_frame(8'h00, 0);
    compare("t4 timeout");
    frame(JUMP, 1'b0);
    compare("t4 recover");

    // 5: typematic repeats of the jump make
    frame(8'hF0, 1'b0);
    frame(JUMP, 1'b0);
    frame(JUMP, 1'b0);
    frame(JUMP, 1'b0);
    frame(JUMP, 1'b0);
    compare("t5");

    // 6: reset in the middle of a frame; the remaining bits are all ones
    f = frame_bits(8'hF0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    ps2_data = f[5];
    wait_cyc(30);
    ps2_clk = 1'b0;
    wait_cyc(30);
    reset = 1'b1;
    #1;
    chk("t6 outputs on mid-frame reset", 32'({scan_code, scan_valid, is_break, is_ext, frame_error, jump, jump_held}), 32'd0);
    wait_cyc(30);
    ps2_clk = 1'b1;
    wait_cyc(20);
    reset = 1'b0;
    wait_cyc(10);
    m_held = 0; m_brk = 0; m_ext = 0;
    obs_q.delete(); obs_ferr = 0; obs_jump = 0; orphan_jump = 0;
    for (int i = 6; i < 11; i++) send_bit(f[i]);
    wait_cyc(100);
    compare("t6 frame remainder");
    frame(8'h1C, 1'b0);
    compare("t6 next frame");

    // 6b: short ps2_clk glitch with data low must not start a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cyc(3);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(50);
    frame(JUMP, 1'b0);
    compare("t6 glitch");

    // Random mix of prefixes, jump codes, other codes and parity errors
    for (int n = 0; n < 12; n++) begin
      b = codes[$urandom_range(0, 4)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      frame(b, bad);
    end
    compare("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
